// File: rtl/win_judge_pkg.sv
// Shared types and constant helpers for the parametrised connect-N judge:
// direction codes, scan FSM states and per-direction window geometry.
package win_judge_pkg;

   localparam logic [1:0] DIR_V    = 2'd0;
   localparam logic [1:0] DIR_H    = 2'd1;
   localparam logic [1:0] DIR_RISE = 2'd2;
   localparam logic [1:0] DIR_FALL = 2'd3;

   // Scan states are encoded so that SCAN_x == direction code + 1.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SCAN_V    = 3'd1,
      ST_SCAN_H    = 3'd2,
      ST_SCAN_RISE = 3'd3,
      ST_SCAN_FALL = 3'd4,
      ST_RESULT    = 3'd5
   } state_t;

   function automatic int dir_dr(input logic [1:0] dir);
      case (dir)
         DIR_H:    return 0;
         DIR_RISE: return -1;
         default:  return 1;
      endcase
   endfunction

   function automatic int dir_dc(input logic [1:0] dir);
      return (dir == DIR_V) ? 0 : 1;
   endfunction

   function automatic int dir_row_first(input logic [1:0] dir, input int wl);
      return (dir == DIR_RISE) ? wl - 1 : 0;
   endfunction

   function automatic int dir_row_last(input logic [1:0] dir, input int rows, input int wl);
      return (dir == DIR_V || dir == DIR_FALL) ? rows - wl : rows - 1;
   endfunction

   function automatic int dir_col_last(input logic [1:0] dir, input int cols, input int wl);
      return (dir == DIR_V) ? cols - 1 : cols - wl;
   endfunction

   function automatic int win_count(input logic [1:0] dir, input int rows, input int cols,
                                    input int wl);
      return (dir_row_last(dir, rows, wl) - dir_row_first(dir, wl) + 1) *
             (dir_col_last(dir, cols, wl) + 1);
   endfunction

   function automatic logic [1:0] state_dir(input state_t s);
      case (s)
         ST_SCAN_H:    return DIR_H;
         ST_SCAN_RISE: return DIR_RISE;
         ST_SCAN_FALL: return DIR_FALL;
         default:      return DIR_V;
      endcase
   endfunction

   // First enabled scan state strictly after s, or RESULT when none remain.
   function automatic state_t next_scan(input state_t s, input logic [3:0] mask);
      state_t n;
      n = ST_RESULT;
      for (int d = 3; d >= 0; d--) begin
         if (mask[d] && d >= int'(s)) n = state_t'(3'(d + 1));
      end
      return n;
   endfunction

endpackage

// File: rtl/win_judge_param_if.sv
// Request/result bus between the game controller and the judge.
// The master drives the board and handshakes; the slave is the judge.
interface win_judge_param_if #(
   parameter int ROWS = 6,
   parameter int COLS = 7
);
   localparam int NC = ROWS * COLS;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   logic [NC-1:0] occupied;
   logic [NC-1:0] whos;
   logic          op_valid;
   logic          op_ready;
   logic          re_valid;
   logic          re_ready;
   logic          re_is_finished;
   logic          re_draw;
   logic          re_winner;
   logic [1:0]    re_dir;
   logic [RW-1:0] re_row;
   logic [CW-1:0] re_col;

   modport master (
      output occupied, whos, op_valid, re_ready,
      input  op_ready, re_valid, re_is_finished, re_draw, re_winner, re_dir, re_row, re_col
   );

   modport slave (
      input  occupied, whos, op_valid, re_ready,
      output op_ready, re_valid, re_is_finished, re_draw, re_winner, re_dir, re_row, re_col
   );
endinterface

// File: rtl/win_window.sv
// Combinational check of one WIN_LEN-long window starting at (row, col)
// in direction dir; cells falling off the board count as empty.
module win_window
   import win_judge_pkg::*;
#(
   parameter int ROWS    = 6,
   parameter int COLS    = 7,
   parameter int WIN_LEN = 4,
   parameter int RW      = 3,
   parameter int CW      = 3
) (
   input  logic [ROWS*COLS-1:0] i_occ,
   input  logic [ROWS*COLS-1:0] i_whos,
   input  logic [RW-1:0]        i_row,
   input  logic [CW-1:0]        i_col,
   input  logic [1:0]           i_dir,
   output logic                 o_hit,
   output logic                 o_player
);
   localparam int NC = ROWS * COLS;
   localparam int IW = (NC > 1) ? $clog2(NC) : 1;

   logic          w_all_occ;
   logic          w_all1;
   logic          w_all0;
   int            w_rk;
   int            w_ck;
   logic [IW-1:0] w_idx;

   always_comb begin
      w_all_occ = 1'b1;
      w_all1    = 1'b1;
      w_all0    = 1'b1;
      w_rk      = 0;
      w_ck      = 0;
      w_idx     = '0;
      for (int k = 0; k < WIN_LEN; k++) begin
         w_rk = int'(i_row) + dir_dr(i_dir) * k;
         w_ck = int'(i_col) + dir_dc(i_dir) * k;
         if (w_rk >= 0 && w_rk < ROWS && w_ck >= 0 && w_ck < COLS) begin
            w_idx     = IW'(w_rk * COLS + w_ck);
            w_all_occ = w_all_occ & i_occ[w_idx];
            w_all1    = w_all1 & i_whos[w_idx];
            w_all0    = w_all0 & ~i_whos[w_idx];
         end else begin
            w_all_occ = 1'b0;
         end
      end
   end

   assign o_hit    = w_all_occ & (w_all1 | w_all0);
   assign o_player = w_all1;

endmodule

// File: rtl/win_judge_param.sv
// Parametrised connect-N judge: snapshots the board on op handshake, scans one
// window per cycle over the enabled directions and reports the first win.
module win_judge_param
   import win_judge_pkg::*;
#(
   parameter int         ROWS     = 6,
   parameter int         COLS     = 7,
   parameter int         WIN_LEN  = 4,
   parameter logic [3:0] DIR_MASK = 4'b1111
) (
   input logic              clk,
   input logic              rst,
   win_judge_param_if.slave bus
);
   localparam int NC = ROWS * COLS;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   if (WIN_LEN < 2 || WIN_LEN > ROWS || WIN_LEN > COLS) begin : g_bad_win_len
      $error("win_judge_param: WIN_LEN must satisfy 2 <= WIN_LEN <= min(ROWS, COLS)");
   end

   state_t        r_state;
   logic [NC-1:0] r_occ;
   logic [NC-1:0] r_whos;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic          r_op_ready;
   logic          r_re_valid;
   logic          r_fin;
   logic          r_draw;
   logic          r_winner;
   logic [1:0]    r_dir;
   logic [RW-1:0] r_orow;
   logic [CW-1:0] r_ocol;

   logic [1:0]    w_dir;
   logic          w_hit;
   logic          w_player;
   logic          w_op_fire;
   state_t        w_next_scan;
   logic [RW-1:0] w_next_row0;
   logic [RW-1:0] w_row_last;
   logic [CW-1:0] w_col_last;

   assign w_dir       = state_dir(r_state);
   assign w_op_fire   = bus.op_valid & r_op_ready;
   assign w_next_scan = next_scan(r_state, DIR_MASK);
   assign w_next_row0 = RW'(dir_row_first(state_dir(w_next_scan), WIN_LEN));
   assign w_row_last  = RW'(dir_row_last(w_dir, ROWS, WIN_LEN));
   assign w_col_last  = CW'(dir_col_last(w_dir, COLS, WIN_LEN));

   win_window #(
      .ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN), .RW(RW), .CW(CW)
   ) u_window (
      .i_occ   (r_occ),
      .i_whos  (r_whos),
      .i_row   (r_row),
      .i_col   (r_col),
      .i_dir   (w_dir),
      .o_hit   (w_hit),
      .o_player(w_player)
   );

   // Board snapshot is pure data: captured on accept, never reset.
   always_ff @(posedge clk) begin
      if (w_op_fire) begin
         r_occ  <= bus.occupied;
         r_whos <= bus.whos;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_row      <= '0;
         r_col      <= '0;
         r_op_ready <= 1'b1;
         r_re_valid <= 1'b0;
         r_fin      <= 1'b0;
         r_draw     <= 1'b0;
         r_winner   <= 1'b0;
         r_dir      <= 2'd0;
         r_orow     <= '0;
         r_ocol     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_op_fire) begin
                  r_op_ready <= 1'b0;
                  r_state    <= w_next_scan;
                  r_row      <= w_next_row0;
                  r_col      <= '0;
                  if (w_next_scan == ST_RESULT) begin
                     r_re_valid <= 1'b1;
                     r_draw     <= &bus.occupied;
                  end
               end
            end
            ST_SCAN_V, ST_SCAN_H, ST_SCAN_RISE, ST_SCAN_FALL: begin
               if (w_hit) begin
                  r_state    <= ST_RESULT;
                  r_re_valid <= 1'b1;
                  r_fin      <= 1'b1;
                  r_winner   <= w_player;
                  r_dir      <= w_dir;
                  r_orow     <= r_row;
                  r_ocol     <= r_col;
               end else if (r_col == w_col_last) begin
                  r_col <= '0;
                  if (r_row == w_row_last) begin
                     r_state <= w_next_scan;
                     r_row   <= w_next_row0;
                     if (w_next_scan == ST_RESULT) begin
                        r_re_valid <= 1'b1;
                        r_draw     <= &r_occ;
                     end
                  end else begin
                     r_row <= r_row + 1'b1;
                  end
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            ST_RESULT: begin
               if (bus.re_ready) begin
                  r_state    <= ST_IDLE;
                  r_op_ready <= 1'b1;
                  r_re_valid <= 1'b0;
                  r_fin      <= 1'b0;
                  r_draw     <= 1'b0;
                  r_winner   <= 1'b0;
                  r_dir      <= 2'd0;
                  r_orow     <= '0;
                  r_ocol     <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.op_ready       = r_op_ready;
   assign bus.re_valid       = r_re_valid;
   assign bus.re_is_finished = r_fin;
   assign bus.re_draw        = r_draw;
   assign bus.re_winner      = r_winner;
   assign bus.re_dir         = r_dir;
   assign bus.re_row         = r_orow;
   assign bus.re_col         = r_ocol;

endmodule

// File: tb/tb_win_judge_param.sv
// Scoreboard bench for win_judge_param: directed boards from the test plan,
// random boards against a reference scan, backpressure, reset abort, DIR_MASK.
module tb_win_judge_param;

   typedef struct {
      logic fin;
      logic draw;
      logic winner;
      int   dir;
      int   row;
      int   col;
      int   lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   win_judge_param_if #(.ROWS(6), .COLS(7)) bus ();
   win_judge_param_if #(.ROWS(6), .COLS(7)) busv ();

   win_judge_param #(.ROWS(6), .COLS(7), .WIN_LEN(4), .DIR_MASK(4'b1111)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   win_judge_param #(.ROWS(6), .COLS(7), .WIN_LEN(4), .DIR_MASK(4'b0001)) dut_v (
      .clk(clk), .rst(rst), .bus(busv.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [41:0] rnd42();
      logic [63:0] v;
      v = {$urandom, $urandom};
      return v[41:0];
   endfunction

   function automatic exp_t mk(input logic fin, input logic draw, input logic winner,
                               input int dir, input int row, input int col, input int lat);
      exp_t e;
      e.fin = fin; e.draw = draw; e.winner = winner;
      e.dir = dir; e.row = row; e.col = col; e.lat = lat;
      return e;
   endfunction

   // Reference scan straight from the direction table; lat is the cycle of re_valid.
   function automatic exp_t model(input logic [41:0] occ, input logic [41:0] wh,
                                  input logic [3:0] mask);
      exp_t e;
      int idx, rlo, rhi, chi, dr, dc, p;
      bit ok, a1, a0;
      e = mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      idx = 0;
      for (int d = 0; d < 4; d++) begin
         if (mask[d]) begin
            dr  = (d == 0 || d == 3) ? 1 : (d == 1) ? 0 : -1;
            dc  = (d == 0) ? 0 : 1;
            rlo = (d == 2) ? 3 : 0;
            rhi = (d == 0 || d == 3) ? 2 : 5;
            chi = (d == 0) ? 6 : 3;
            for (int r = rlo; r <= rhi; r++) begin
               for (int c = 0; c <= chi; c++) begin
                  ok = 1; a1 = 1; a0 = 1;
                  for (int k = 0; k < 4; k++) begin
                     p  = (r + dr * k) * 7 + c + dc * k;
                     ok = ok & occ[p];
                     a1 = a1 & wh[p];
                     a0 = a0 & !wh[p];
                  end
                  if (ok && (a1 || a0) && !e.fin)
                     e = mk(1'b1, 1'b0, a1, d, r, c, idx + 2);
                  idx++;
               end
            end
         end
      end
      if (!e.fin) begin
         e.draw = &occ;
         e.lat  = idx + 1;
      end
      return e;
   endfunction

   task automatic do_req(input logic [41:0] occ, input logic [41:0] wh, input exp_t e,
                         input int hold, input bit pulse);
      exp_t x;
      int   m;
      bit   got;
      @(negedge clk);
      chk("op_ready_idle", bus.op_ready, 1);
      bus.occupied = occ;
      bus.whos     = wh;
      bus.op_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = 1'b0;
      chk("op_ready_busy", bus.op_ready, 0);
      m = 0;
      got = 0;
      while (!got && m < 200) begin
         if (bus.re_valid) begin
            got = 1;
         end else begin
            if (pulse) begin
               bus.op_valid = (m < 4);
               bus.occupied = rnd42();
               bus.whos     = rnd42();
            end
            @(posedge clk);
            m++;
            @(negedge clk);
         end
      end
      bus.op_valid = 1'b0;
      x = sb.pop_front();
      chk("re_valid_seen", got, 1);
      if (!got) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      chk("latency", m + 1, x.lat);
      chk("finished", bus.re_is_finished, x.fin);
      chk("draw", bus.re_draw, x.draw);
      chk("winner", bus.re_winner, x.winner);
      chk("dir", bus.re_dir, x.dir);
      chk("row", bus.re_row, x.row);
      chk("col", bus.re_col, x.col);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", bus.re_valid, 1);
         chk("hold_op_ready", bus.op_ready, 0);
         chk("hold_fields", {bus.re_is_finished, bus.re_draw, bus.re_winner, bus.re_dir,
                             bus.re_row, bus.re_col},
             {x.fin, x.draw, x.winner, 2'(x.dir), 3'(x.row), 3'(x.col)});
      end
      bus.re_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.re_ready = 1'b0;
      chk("clr_valid", bus.re_valid, 0);
      chk("clr_op_ready", bus.op_ready, 1);
      chk("clr_fields", {bus.re_is_finished, bus.re_draw, bus.re_winner, bus.re_dir,
                         bus.re_row, bus.re_col}, 0);
      repeat (3) @(negedge clk);
      chk("single_result", bus.re_valid, 0);
   endtask

   initial begin
      logic [41:0] occ, wh;
      exp_t        x;
      int          m;
      bit          seen;

      bus.occupied = '0; bus.whos = '0; bus.op_valid = 1'b0; bus.re_ready = 1'b0;
      busv.occupied = '0; busv.whos = '0; busv.op_valid = 1'b0; busv.re_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_op_ready", bus.op_ready, 1);
      chk("rst_re_valid", bus.re_valid, 0);
      chk("rst_fields", {bus.re_is_finished, bus.re_draw, bus.re_winner, bus.re_dir,
                         bus.re_row, bus.re_col}, 0);
      rst = 1'b0;

      // Vertical win for player 1 in column 0, with op_valid pulses during the scan.
      occ = '0;
      occ[0] = 1'b1; occ[7] = 1'b1; occ[14] = 1'b1; occ[21] = 1'b1;
      do_req(occ, occ, mk(1'b1, 1'b0, 1'b1, 0, 0, 0, 2), 0, 1'b1);

      do_req('0, '0, mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 70), 0, 1'b0);

      wh = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            wh[r * 7 + c] = 1'((r + c / 2) % 2);
      do_req('1, wh, mk(1'b0, 1'b1, 1'b0, 0, 0, 0, 70), 0, 1'b0);

      // Rising diagonal for player 0 starting at (5,3), held under backpressure.
      occ = '0;
      occ[38] = 1'b1; occ[32] = 1'b1; occ[26] = 1'b1; occ[20] = 1'b1;
      do_req(occ, '0, mk(1'b1, 1'b0, 1'b0, 2, 5, 3, 58), 5, 1'b1);

      for (int i = 0; i < 8; i++) begin
         occ = (i % 2 == 0) ? (rnd42() & rnd42()) : (rnd42() | rnd42());
         if (i == 7) occ = '1;
         wh = rnd42();
         do_req(occ, wh, model(occ, wh, 4'b1111), (i == 3) ? 2 : 0, 1'(i % 3 == 0));
      end

      // Reset in cycle 10 of a scan aborts it with no result afterwards.
      @(negedge clk);
      bus.occupied = '0; bus.whos = '0; bus.op_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_op_ready", bus.op_ready, 1);
      chk("abort_re_valid", bus.re_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (90) begin
         @(negedge clk);
         if (bus.re_valid) seen = 1;
      end
      chk("no_result_after_rst", seen, 0);

      // Vertical-only judge on an empty board.
      @(negedge clk);
      busv.occupied = '0; busv.whos = '0; busv.op_valid = 1'b1;
      sb.push_back(model('0, '0, 4'b0001));
      @(posedge clk);
      @(negedge clk);
      busv.op_valid = 1'b0;
      m = 0;
      while (!busv.re_valid && m < 100) begin
         @(posedge clk);
         m++;
         @(negedge clk);
      end
      x = sb.pop_front();
      chk("v_latency", m + 1, 22);
      chk("v_latency_model", m + 1, x.lat);
      chk("v_finished", busv.re_is_finished, 0);
      chk("v_draw", busv.re_draw, 0);
      busv.re_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      busv.re_ready = 1'b0;
      chk("v_clr_valid", busv.re_valid, 0);
      chk("v_op_ready", busv.op_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/win_judge_param.md
Name: win_judge_param

Overview:
- Parametrised successor of the fixed 6x7 connect-4 judge.
- Snapshots an ROWS x COLS board on an op handshake, then scans every WIN_LEN-long window, one window per cycle, in the enabled directions.
- Returns finished / draw / winner plus the direction and start cell of the first winning line on a result handshake.
- Sits between the game controller (board registers) and the move/turn FSM.

Parameters:
- ROWS, 6, board rows; row 0 is the top row.
- COLS, 7, board columns.
- WIN_LEN, 4, line length that wins. Elaboration error unless 2 <= WIN_LEN <= min(ROWS, COLS).
- DIR_MASK, 4'b1111, per-direction scan enable; bit0 V, bit1 H, bit2 RISE, bit3 FALL.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- occupied  in  ROWS*COLS  cell (r,c) is bit r*COLS+c; 1 = disc present.
- whos  in  ROWS*COLS  owner of each cell; meaningful only where occupied.
- op_valid  in  1  request valid.
- op_ready  out  1  judge idle, accepts request.
- re_valid  out  1  result valid.
- re_ready  in  1  consumer accepts result.
- re_is_finished  out  1  a winning line exists.
- re_draw  out  1  board full and no win.
- re_winner  out  1  whos value of the winning line; 0 when not finished.
- re_dir  out  2  0 V, 1 H, 2 RISE, 3 FALL; 0 when not finished.
- re_row  out  RW=max(1,$clog2(ROWS))  start row of the winning line.
- re_col  out  CW=max(1,$clog2(COLS))  start column of the winning line.

Behaviour:
- Reset (async, active-high): op_ready=1; re_valid, re_is_finished, re_draw, re_winner, re_dir, re_row, re_col = 0; state IDLE.
  - Reset asserted mid-scan or mid-result aborts immediately. No result is emitted for the aborted request.
- Handshakes:
  - op_fire = op_valid & op_ready. re_fire = re_valid & re_ready.
  - op_ready is 0 from the cycle after op_fire until the cycle after re_fire. op_valid while busy is ignored.
- Snapshot: on op_fire, occupied and whos are latched internally. Input changes during the scan have no effect.
- Direction windows (start (r,c); cell k = (r+dr*k, c+dc*k)):
  - V (dr=1, dc=0): r 0..ROWS-WIN_LEN, c 0..COLS-1.
  - H (dr=0, dc=1): r 0..ROWS-1, c 0..COLS-WIN_LEN.
  - RISE (dr=-1, dc=1): r WIN_LEN-1..ROWS-1, c 0..COLS-WIN_LEN.
  - FALL (dr=1, dc=1): r 0..ROWS-WIN_LEN, c 0..COLS-WIN_LEN.
- Hit condition: all WIN_LEN cells occupied AND whos all 1 or all 0.
- States: IDLE -> SCAN_V -> SCAN_H -> SCAN_RISE -> SCAN_FALL -> RESULT -> IDLE.
  - A disabled direction's state is skipped with zero cycles.
  - Within a state, windows are visited row-major with column innermost, starting at the lowest start row.
- On a hit:
  - The next cycle is RESULT with re_valid=1, re_is_finished=1, re_draw=0, and winner/dir/row/col of that window.
  - This is the first hit in scan order.
- After the last window of the last enabled direction with no hit:
  - RESULT with re_is_finished=0.
  - re_draw = &occupied_snapshot.
- DIR_MASK=0: RESULT one cycle after op_fire, with draw evaluated as above.
- Latency: op_fire at edge 0; window i (0-based in scan order) is evaluated in cycle i+1.
  - Hit at window i gives re_valid from cycle i+2.
  - No hit gives re_valid from cycle N+1, N = total enabled windows (69 at defaults: 21+24+12+12).
- RESULT: all result outputs held stable until re_fire. On re_fire all result outputs clear and op_ready=1 the next cycle.
- Counters: row/col counters sized RW/CW, never wrap past their limits. Limits are computed from parameters as constants.

Decomposition:
- Package win_judge_pkg: direction encoding (DIR_V..DIR_FALL), state enum, dr/dc constant tables, window-count functions.
- Sub-module win_window (combinational):
  - Inputs: snapshot, r, c, dir.
  - Outputs: hit, player.
  - Generates WIN_LEN cell indices.

Test Plan:
- Vertical win, player 1 at bits 0,7,14,21 (occupied = whos) -> re_valid at cycle 2; finished=1, winner=1, dir=0, row=0, col=0, draw=0.
- Empty board -> re_valid at cycle 70; finished=0, draw=0; op_ready returns 1 the cycle after re_fire.
- Full board, whos(r,c) = (r + c/2) mod 2 -> re_valid at cycle 70; finished=0, draw=1.
- RISE win, player 0 at (5,3),(4,4),(3,5),(2,6) -> re_valid at cycle 58; dir=2, row=5, col=3, winner=0.
- Backpressure and ignore:
  - Hold re_ready=0 for 5 cycles after re_valid -> outputs stable, op_ready=0.
  - op_valid pulsed during the scan -> ignored; exactly one result per accepted request.
- Reset and DIR_MASK:
  - Assert rst at cycle 10 of a scan -> op_ready=1 and re_valid=0 immediately; no result after release.
  - DIR_MASK=4'b0001 with an empty board -> re_valid at cycle 22.
